core_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the 5-stage core (FE/ID/EX/MM/WB).
- Drives the stall and flush inputs of every stage, which were previously tied to 0.
- Provides EX-operand forwarding selects, load-use interlock, taken-branch squash and a multi-cycle EX (multiplier) occupancy FSM.
- Keeps saturating stall/flush performance counters.
- Sits in CORE beside the stage instances; all stage-facing outputs are combinational from current pipeline state.

---
 rtl/core_hazard_ctrl_pkg.sv | 15 +
 rtl/core_mul_occupancy.sv | 48 ++++
 rtl/core_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_core_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_hazard_ctrl_pkg.sv
// rtl/core_hazard_ctrl_pkg.sv - shared forwarding encodings and hazard FSM states
package core_hazard_ctrl_pkg;

  localparam int FWD_SEL_W = 2;

  localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_EXMM    = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_MMWB    = 2'b10;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/core_mul_occupancy.sv
// rtl/core_mul_occupancy.sv - holds a multi-cycle mul in EX for MUL_LAT cycles
module core_mul_occupancy
  import core_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ex_valid,
  input  logic ex_is_mul,
  output logic mul_busy
);

  localparam int MCNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUL_LAT - 1);

  hz_state_e         state_q, state_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;

  assign mul_busy = ex_valid & ex_is_mul & (mcnt_q != MCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // A fresh occupancy always counts from zero, whatever mcnt was left at.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (en) begin
      if (mul_busy) begin
        state_d = HZ_BUSY;
        mcnt_d  = ((state_q == HZ_BUSY) ? mcnt_q : '0) + 1'b1;
      end else begin
        state_d = HZ_IDLE;
        mcnt_d  = '0;
      end
    end
  end

endmodule

// File: rtl/core_hazard_ctrl.sv
// rtl/core_hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage pipeline
module core_hazard_ctrl
  import core_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int MUL_LAT    = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic                  ex_reg_wr,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mul,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  ex_branch_taken,
  input  logic                  mm_valid,
  input  logic                  mm_reg_wr,
  input  logic [REG_ADDR_W-1:0] mm_rd,
  input  logic                  wb_valid,
  input  logic                  wb_reg_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall_fe,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_fe_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mm,
  output logic [FWD_SEL_W-1:0]  fwd_sel1,
  output logic [FWD_SEL_W-1:0]  fwd_sel2,
  output logic                  mul_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // r0 is hardwired zero, so it never produces a hazard or a forward.
  function automatic logic wmatch(input logic v, input logic w,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] s);
    return v & w & (rd == s) & (s != '0);
  endfunction

  logic id_s1, id_s2, ex_hit, mm_hit, wb_hit, raw_stall, br;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  core_mul_occupancy #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ex_valid  (ex_valid),
    .ex_is_mul (ex_is_mul),
    .mul_busy  (mul_busy)
  );

  assign id_s1  = id_valid & id_rs1_used;
  assign id_s2  = id_valid & id_rs2_used;
  assign ex_hit = (id_s1 & wmatch(ex_valid, ex_reg_wr, ex_rd, id_rs1)) |
                  (id_s2 & wmatch(ex_valid, ex_reg_wr, ex_rd, id_rs2));
  assign mm_hit = (id_s1 & wmatch(mm_valid, mm_reg_wr, mm_rd, id_rs1)) |
                  (id_s2 & wmatch(mm_valid, mm_reg_wr, mm_rd, id_rs2));
  assign wb_hit = (id_s1 & wmatch(wb_valid, wb_reg_wr, wb_rd, id_rs1)) |
                  (id_s2 & wmatch(wb_valid, wb_reg_wr, wb_rd, id_rs2));
  assign br     = ex_valid & ex_branch_taken;

  always_comb begin
    fwd_sel1  = FWD_REGFILE;
    fwd_sel2  = FWD_REGFILE;
    raw_stall = ex_hit | mm_hit | wb_hit;
    if (FWD_EN != 0) begin
      raw_stall = ex_is_load & ex_hit;
      if (wmatch(mm_valid, mm_reg_wr, mm_rd, ex_rs1))      fwd_sel1 = FWD_EXMM;
      else if (wmatch(wb_valid, wb_reg_wr, wb_rd, ex_rs1)) fwd_sel1 = FWD_MMWB;
      if (wmatch(mm_valid, mm_reg_wr, mm_rd, ex_rs2))      fwd_sel2 = FWD_EXMM;
      else if (wmatch(wb_valid, wb_reg_wr, wb_rd, ex_rs2)) fwd_sel2 = FWD_MMWB;
    end
  end

  always_comb begin
    stall_fe    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    flush_fe_id = 1'b0;
    flush_id_ex = 1'b0;
    flush_ex_mm = 1'b0;
    if (mul_busy) begin
      stall_fe    = 1'b1;
      stall_id    = 1'b1;
      stall_ex    = 1'b1;
      flush_ex_mm = 1'b1;
    end else if (br) begin
      flush_fe_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (raw_stall) begin
      stall_fe    = 1'b1;
      stall_id    = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (en && stall_fe && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 1'b1;
    if (en && flush_fe_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb/tb_core_hazard_ctrl.sv - directed self-checking bench for core_hazard_ctrl
module tb_core_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_reg_wr, ex_is_load, ex_is_mul, ex_branch_taken;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic       mm_valid, mm_reg_wr, wb_valid, wb_reg_wr;
  logic [4:0] mm_rd, wb_rd;

  logic        a_stall_fe, a_stall_id, a_stall_ex, a_flush_fe_id, a_flush_id_ex, a_flush_ex_mm, a_mul_busy;
  logic [1:0]  a_fwd_sel1, a_fwd_sel2;
  logic [31:0] a_stall_cnt, a_flush_cnt;

  logic        b_stall_fe, b_stall_id, b_stall_ex, b_flush_fe_id, b_flush_id_ex, b_flush_ex_mm, b_mul_busy;
  logic [1:0]  b_fwd_sel1, b_fwd_sel2;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .MUL_LAT(3), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
    .mm_valid(mm_valid), .mm_reg_wr(mm_reg_wr), .mm_rd(mm_rd),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
    .stall_fe(a_stall_fe), .stall_id(a_stall_id), .stall_ex(a_stall_ex),
    .flush_fe_id(a_flush_fe_id), .flush_id_ex(a_flush_id_ex), .flush_ex_mm(a_flush_ex_mm),
    .fwd_sel1(a_fwd_sel1), .fwd_sel2(a_fwd_sel2), .mul_busy(a_mul_busy),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  // No-forwarding variant with narrow counters so saturation is reachable.
  core_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .MUL_LAT(3), .CNT_W(2)) u_dut_nf (
    .clk(clk), .rst_n(rst_n), .en(en),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
    .mm_valid(mm_valid), .mm_reg_wr(mm_reg_wr), .mm_rd(mm_rd),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
    .stall_fe(b_stall_fe), .stall_id(b_stall_id), .stall_ex(b_stall_ex),
    .flush_fe_id(b_flush_fe_id), .flush_id_ex(b_flush_id_ex), .flush_ex_mm(b_flush_ex_mm),
    .fwd_sel1(b_fwd_sel1), .fwd_sel2(b_fwd_sel2), .mul_busy(b_mul_busy),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    en = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_reg_wr = 0; ex_is_load = 0; ex_is_mul = 0; ex_branch_taken = 0;
    ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    mm_valid = 0; mm_reg_wr = 0; mm_rd = 0;
    wb_valid = 0; wb_reg_wr = 0; wb_rd = 0;
  endtask

  task automatic load_use();
    clr();
    ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 5'd3;
    id_valid = 1; id_rs2 = 5'd3; id_rs2_used = 1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #2;
    check("rst_stall_fe", a_stall_fe, 0);
    check("rst_flush_id_ex", a_flush_id_ex, 0);
    check("rst_mul_busy", a_mul_busy, 0);
    check("rst_fwd", {a_fwd_sel1, a_fwd_sel2}, 0);
    check("rst_stall_cnt", a_stall_cnt, 0);
    check("rst_flush_cnt", a_flush_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Forwarding priority and r0 exclusion
    ex_valid = 1; ex_rs1 = 5'd5;
    mm_valid = 1; mm_reg_wr = 1; mm_rd = 5'd5;
    wb_valid = 1; wb_reg_wr = 1; wb_rd = 5'd5;
    #1;
    check("fwd_exmm_prio", a_fwd_sel1, 2'b01);
    check("fwd_sel2_none", a_fwd_sel2, 2'b00);
    check("nf_fwd_const", b_fwd_sel1, 2'b00);
    mm_rd = 5'd6; ex_rs2 = 5'd6;
    #1;
    check("fwd_mmwb", a_fwd_sel1, 2'b10);
    check("fwd_sel2_exmm", a_fwd_sel2, 2'b01);
    ex_rs1 = 0; ex_rs2 = 0; mm_rd = 0; wb_rd = 0;
    #1;
    check("fwd_r0", {a_fwd_sel1, a_fwd_sel2}, 0);
    tick();

    // Load-use interlock
    load_use();
    #1;
    check("lu_stall_fe", a_stall_fe, 1);
    check("lu_stall_id", a_stall_id, 1);
    check("lu_flush_id_ex", a_flush_id_ex, 1);
    check("lu_stall_ex", a_stall_ex, 0);
    tick();
    clr();
    #1;
    check("lu_stall_cnt", a_stall_cnt, 1);
    load_use();
    id_rs2_used = 0;
    #1;
    check("lu_unused_src", a_stall_fe, 0);
    tick();

    // Taken branch beats load-use
    load_use();
    ex_branch_taken = 1;
    #1;
    check("br_flush_fe_id", a_flush_fe_id, 1);
    check("br_flush_id_ex", a_flush_id_ex, 1);
    check("br_stall_fe", a_stall_fe, 0);
    tick();
    clr();
    #1;
    check("br_flush_cnt", a_flush_cnt, 1);
    check("br_stall_cnt", a_stall_cnt, 1);

    // Multiplier occupancy: two busy cycles, released on the third
    ex_valid = 1; ex_is_mul = 1;
    #1;
    check("mul_c1_busy", a_mul_busy, 1);
    check("mul_c1_stall_ex", a_stall_ex, 1);
    check("mul_c1_flush_ex_mm", a_flush_ex_mm, 1);
    check("mul_c1_flush_id_ex", a_flush_id_ex, 0);
    tick();
    check("mul_c2_busy", a_mul_busy, 1);
    tick();
    check("mul_c3_busy", a_mul_busy, 0);
    check("mul_c3_stall_ex", a_stall_ex, 0);
    check("mul_stall_cnt", a_stall_cnt, 3);
    tick();
    check("mul_restart_busy", a_mul_busy, 1);

    // Enable low freezes mcnt and counters
    en = 0;
    tick();
    tick();
    check("en0_busy_held", a_mul_busy, 1);
    check("en0_stall_cnt", a_stall_cnt, 3);
    en = 1;
    tick();
    check("en1_stall_cnt", a_stall_cnt, 4);
    check("en1_busy_mcnt1", a_mul_busy, 1);

    // Reset mid-BUSY clears counters at once and restarts the occupancy
    #1;
    rst_n = 0;
    #1;
    check("rst_mid_stall_cnt", a_stall_cnt, 0);
    check("rst_mid_flush_cnt", a_flush_cnt, 0);
    tick();
    rst_n = 1;
    #1;
    check("rst_rel_c1_busy", a_mul_busy, 1);
    tick();
    check("rst_rel_c2_busy", a_mul_busy, 1);
    tick();
    check("rst_rel_c3_busy", a_mul_busy, 0);
    clr();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();

    // No forwarding: MM and WB writers interlock, counter saturates at 3
    mm_valid = 1; mm_reg_wr = 1; mm_rd = 5'd7;
    id_valid = 1; id_rs1 = 5'd7; id_rs1_used = 1;
    ex_valid = 1; ex_rs1 = 5'd7;
    #1;
    check("nf_mm_stall_fe", b_stall_fe, 1);
    check("nf_mm_flush_id_ex", b_flush_id_ex, 1);
    check("nf_fwd_sel1", b_fwd_sel1, 2'b00);
    check("fw_no_stall", a_stall_fe, 0);
    check("fw_fwd_sel1", a_fwd_sel1, 2'b01);
    tick();
    tick();
    check("nf_stall_cnt2", b_stall_cnt, 2);
    mm_valid = 0; wb_valid = 1; wb_reg_wr = 1; wb_rd = 5'd7;
    #1;
    check("nf_wb_stall_fe", b_stall_fe, 1);
    check("fw_wb_fwd_sel1", a_fwd_sel1, 2'b10);
    tick();
    tick();
    tick();
    check("nf_stall_cnt_sat", b_stall_cnt, 3);
    check("fw_stall_cnt_zero", a_stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
